rename_unit_p: RTL and testbench
================================

# rename_unit_p

Parametrised register-rename stage with per-tag completion tracking. Sits between decode and dispatch. It maps architectural source registers to in-flight ROB tags and allocates the destination mapping. It tracks which ROB tags have already broadcast on the CDB, so operands report ready without a reservation-station wakeup, and it clears mappings on commit and flush.

## Interface
Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hard-wired zero.
- REG_W, 5, architectural register index width; 2^REG_W >= NUM_REGS.
- TAG_W, 5, ROB tag width; all-ones (NONE) means "no producer", so 2^TAG_W-1 usable tags.

Ports:
- clk  in  1  clock. Everything is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- issue_valid  in  1  decoded instruction presented this cycle.
- rs, rt  in  REG_W  source register indices.
- rd  in  REG_W  destination register index.
- has_dest  in  1  instruction writes rd.
- rob_alloc_valid  in  1  ROB has a free entry.
- rob_tag_alloc  in  TAG_W  tag of that free entry.
- stall  out  1  combinational: issue_valid & has_dest & ~rob_alloc_valid. The issue is not accepted.
- cdb_valid, cdb_tag  in  1, TAG_W  result broadcast.
- commit_valid, commit_rd, commit_tag  in  1, REG_W, TAG_W  ROB head retirement.
- flush  in  1  mispredict/exception recovery.
- out_valid  out  1  registered: renamed instruction valid.
- rs_tag_out, rt_tag_out  out  TAG_W  producer tag or NONE.
- rs_ready, rt_ready  out  1  operand value available (regfile or completed ROB entry).
- dest_rob_tag_out  out  TAG_W  allocated tag or NONE.

## Operation
- State:
  - RAT[NUM_REGS] of TAG_W bits.
  - done[2^TAG_W] completion bits.
- Accept condition: accept = issue_valid & ~flush & ~stall. An issue with has_dest=0 is accepted even when rob_alloc_valid=0.
- Source lookup (rs; rt is identical) reads RAT state from before this cycle's updates. In priority order:
  - rs==0 or RAT[rs]==NONE -> tag NONE, ready 1.
  - Commit bypass: commit_valid & commit_rd==rs & commit_tag==RAT[rs] -> tag NONE, ready 1.
  - Otherwise -> tag RAT[rs], ready = done[RAT[rs]] | (cdb_valid & cdb_tag==RAT[rs]).
- Destination: on accept with has_dest & rd!=0:
  - RAT[rd] <= rob_tag_alloc.
  - done[rob_tag_alloc] <= 0.
  - dest_rob_tag_out <= rob_tag_alloc.
  - Otherwise dest_rob_tag_out <= NONE.
  - rd==0 with has_dest still consumes the ROB tag: dest_rob_tag_out = rob_tag_alloc, but RAT is unchanged.
- Self-reference: rs==rd in the same instruction gets the old mapping, never its own new tag.
- CDB: cdb_valid sets done[cdb_tag]. Allocation of the same tag in the same cycle wins (done stays 0).
- Commit: commit_valid & RAT[commit_rd]==commit_tag -> RAT[commit_rd] <= NONE. A stale commit (mapping already overwritten) leaves the RAT unchanged. A same-cycle accepted allocation to commit_rd wins over the clear.
- Flush has top priority:
  - All RAT entries become NONE and all done bits clear.
  - Issue, CDB and commit are ignored that cycle.
  - out_valid <= 0.

## Timing
- Reset values:
  - RAT all NONE, done all 0.
  - out_valid 0, rs_ready/rt_ready 1.
  - rs_tag_out/rt_tag_out/dest_rob_tag_out NONE.
- Latency: outputs are registered, one cycle after the accepted issue.
- out_valid pulses 1 for each accepted cycle and is 0 otherwise. Other outputs hold their last value when out_valid=0.
- Back-to-back issue every cycle is supported. Instruction N+1 sees instruction N's RAT write with no bubble.
- stall is combinational from the same-cycle inputs. The upstream stage holds its instruction while stall=1.
- Reset asserted mid-stream clears state immediately (async). The first edge after deassert behaves as post-reset.

## Test plan
- Reset then issue rs=3, rt=4, rd=5, has_dest, tag=2 -> next cycle: out_valid=1, both tags NONE, both ready=1, dest=2. Then issue rs=5 -> rs_tag_out=2, rs_ready=0.
- RAW with CDB:
  - r5->tag 2.
  - cdb_tag=2 in the same cycle as an issue reading r5 -> rs_tag_out=2, rs_ready=1 (bypass).
  - A later read -> ready=1 via the done bit.
- Commit:
  - Stale: r5->2, then r5->7, then commit(r5,2) -> RAT[5] stays 7.
  - Matching: commit(r5,7) -> next read of r5 gives NONE, ready=1.
  - Commit bypass: same-cycle commit and read -> NONE.
- rob_alloc_valid=0 with has_dest=1:
  - stall=1, no out_valid, RAT unchanged.
  - has_dest=0 in the same condition -> accepted.
- Flush with 4 live mappings plus a simultaneous issue -> issue dropped, next reads all NONE/ready.
- Edge cases:
  - rd=0 has_dest -> dest=alloc tag, r0 read stays NONE.
  - rs==rd self-reference gets the old tag.
  - Async reset asserted mid-stream clears all state.

Source files
------------

// File: rtl/rename_unit_p.sv
// rename_unit_p: register-rename stage between decode and dispatch.
// Maps architectural sources to in-flight ROB tags, allocates destination
// mappings, and remembers which tags have already broadcast on the CDB so
// operands can report ready without a reservation-station wakeup.
module rename_unit_p #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic             has_dest,
    input  logic             rob_alloc_valid,
    input  logic [TAG_W-1:0] rob_tag_alloc,
    output logic             stall,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic             commit_valid,
    input  logic [REG_W-1:0] commit_rd,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic             flush,
    output logic             out_valid,
    output logic [TAG_W-1:0] rs_tag_out,
    output logic [TAG_W-1:0] rt_tag_out,
    output logic             rs_ready,
    output logic             rt_ready,
    output logic [TAG_W-1:0] dest_rob_tag_out
);

    localparam logic [TAG_W-1:0] NONE     = '1;
    localparam int               NUM_TAGS = 2 ** TAG_W;

    logic [TAG_W-1:0]    rat [NUM_REGS];
    logic [NUM_TAGS-1:0] done;

    logic             accept;
    logic [TAG_W-1:0] rs_map, rt_map, commit_map;
    logic             commit_hit;
    logic             rs_ready_nxt, rt_ready_nxt;
    logic [TAG_W-1:0] rs_tag_nxt, rt_tag_nxt;

    // Source resolution against pre-update state: returns {ready, tag}.
    function automatic logic [TAG_W:0] lookup(
        input logic [REG_W-1:0] src,
        input logic [TAG_W-1:0] mapped,
        input logic             done_bit,
        input logic             c_valid,
        input logic [REG_W-1:0] c_rd,
        input logic [TAG_W-1:0] c_tag,
        input logic             b_valid,
        input logic [TAG_W-1:0] b_tag
    );
        if (src == '0 || mapped == NONE)
            return {1'b1, NONE};
        // Producer retires this cycle: value is in the regfile by the time we read it.
        if (c_valid && c_rd == src && c_tag == mapped)
            return {1'b1, NONE};
        return {done_bit | (b_valid && b_tag == mapped), mapped};
    endfunction

    assign stall  = issue_valid & has_dest & ~rob_alloc_valid;
    assign accept = issue_valid & ~flush & ~stall;

    // Current mappings; indices beyond NUM_REGS read as "no producer".
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rs_map     = NONE;
        rt_map     = NONE;
        commit_map = NONE;
        if (int'(rs) < NUM_REGS)        rs_map     = rat[rs];
        if (int'(rt) < NUM_REGS)        rt_map     = rat[rt];
        if (int'(commit_rd) < NUM_REGS) commit_map = rat[commit_rd];
        commit_hit = commit_valid && commit_rd != '0 && commit_map == commit_tag;
        {rs_ready_nxt, rs_tag_nxt} = lookup(rs, rs_map, done[rs_map], commit_valid,
                                            commit_rd, commit_tag, cdb_valid, cdb_tag);
        {rt_ready_nxt, rt_tag_nxt} = lookup(rt, rt_map, done[rt_map], commit_valid,
                                            commit_rd, commit_tag, cdb_valid, cdb_tag);
    end

    // RAT and completion bits; later assignments encode priority (alloc > commit, alloc > CDB).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the RAT is reset entry by entry because "no producer" must hold from the first cycle.
            for (int i = 0; i < NUM_REGS; i++) rat[i] <= NONE;
            done <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) rat[i] <= NONE;
            done <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so the last write in program order wins at the edge.
            if (cdb_valid)
                done[cdb_tag] <= 1'b1;
            if (commit_hit)
                rat[commit_rd] <= NONE;
            if (accept && has_dest && rd != '0) begin
                rat[rd]              <= rob_tag_alloc;
                done[rob_tag_alloc]  <= 1'b0;
            end
        end
    end

    // Registered rename result; fields hold their value while out_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid        <= 1'b0;
            rs_tag_out       <= NONE;
            rt_tag_out       <= NONE;
            rs_ready         <= 1'b1;
            rt_ready         <= 1'b1;
            dest_rob_tag_out <= NONE;
        end else begin
            out_valid <= accept;
            if (accept) begin
                rs_tag_out       <= rs_tag_nxt;
                rt_tag_out       <= rt_tag_nxt;
                rs_ready         <= rs_ready_nxt;
                rt_ready         <= rt_ready_nxt;
                dest_rob_tag_out <= has_dest ? rob_tag_alloc : NONE;
            end
        end
    end

endmodule

// File: tb/tb_rename_unit_p.sv
// Directed bench for rename_unit_p: each task drives one scenario and
// compares the packed output word against hand-computed values.
module tb_rename_unit_p;

    localparam logic [4:0] NONE = 5'd31;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, has_dest, rob_alloc_valid;
    logic [4:0] rs, rt, rd, rob_tag_alloc;
    logic       stall;
    logic       cdb_valid, commit_valid, flush;
    logic [4:0] cdb_tag, commit_rd, commit_tag;
    logic       out_valid, rs_ready, rt_ready;
    logic [4:0] rs_tag_out, rt_tag_out, dest_rob_tag_out;

    int passed = 0;
    int total  = 0;

    rename_unit_p #(.NUM_REGS(32), .REG_W(5), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .rs(rs), .rt(rt), .rd(rd), .has_dest(has_dest),
        .rob_alloc_valid(rob_alloc_valid), .rob_tag_alloc(rob_tag_alloc), .stall(stall),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
        .flush(flush), .out_valid(out_valid),
        .rs_tag_out(rs_tag_out), .rt_tag_out(rt_tag_out),
        .rs_ready(rs_ready), .rt_ready(rt_ready), .dest_rob_tag_out(dest_rob_tag_out)
    );

    always #5 clk = ~clk;

    // {out_valid, rs_tag, rs_ready, rt_tag, rt_ready, dest}
    function automatic logic [17:0] obs();
        return {out_valid, rs_tag_out, rs_ready, rt_tag_out, rt_ready, dest_rob_tag_out};
    endfunction

    function automatic logic [17:0] word(input logic v, input logic [4:0] st, input logic sr,
                                         input logic [4:0] tt, input logic tr, input logic [4:0] d);
        return {v, st, sr, tt, tr, d};
    endfunction

    task automatic idle();
        issue_valid = 0; has_dest = 0; rob_alloc_valid = 1; rob_tag_alloc = 0;
        rs = 0; rt = 0; rd = 0;
        cdb_valid = 0; cdb_tag = 0; commit_valid = 0; commit_rd = 0; commit_tag = 0;
        flush = 0;
    endtask

    task automatic set_issue(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                             input logic hd, input logic [4:0] tag);
        issue_valid = 1; rs = s; rt = t; rd = d; has_dest = hd; rob_tag_alloc = tag;
        rob_alloc_valid = 1;
    endtask

    // One rising edge, sample 1 time unit later, then return inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs() !== word(0, NONE, 1, NONE, 1, NONE))
            $display("FAIL reset_outputs got %h exp %h", obs(), word(0, NONE, 1, NONE, 1, NONE));
        else passed++;
        @(negedge clk);
        rst_n = 1;
        #1;
        total++;
        if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall);
        else passed++;
    endtask

    task automatic test_basic();
        set_issue(3, 4, 5, 1, 2); step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, 2))
            $display("FAIL basic_alloc got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, 2));
        else passed++;
        set_issue(5, 0, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, 2, 0, NONE, 1, NONE))
            $display("FAIL basic_raw got %h exp %h", obs(), word(1, 2, 0, NONE, 1, NONE));
        else passed++;
        step();
        total++;
        if (obs() !== word(0, 2, 0, NONE, 1, NONE))
            $display("FAIL basic_hold got %h exp %h", obs(), word(0, 2, 0, NONE, 1, NONE));
        else passed++;
    endtask

    task automatic test_cdb();
        set_issue(5, 5, 0, 0, 0); cdb_valid = 1; cdb_tag = 2; step();
        total++;
        if (obs() !== word(1, 2, 1, 2, 1, NONE))
            $display("FAIL cdb_bypass got %h exp %h", obs(), word(1, 2, 1, 2, 1, NONE));
        else passed++;
        set_issue(5, 0, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, 2, 1, NONE, 1, NONE))
            $display("FAIL cdb_done_bit got %h exp %h", obs(), word(1, 2, 1, NONE, 1, NONE));
        else passed++;
    endtask

    task automatic test_commit();
        set_issue(0, 0, 5, 1, 7); step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, 7))
            $display("FAIL commit_remap got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, 7));
        else passed++;
        // stale commit of old tag 2 together with a read of r5
        set_issue(5, 0, 0, 0, 0); commit_valid = 1; commit_rd = 5; commit_tag = 2; step();
        total++;
        if (obs() !== word(1, 7, 0, NONE, 1, NONE))
            $display("FAIL commit_stale_read got %h exp %h", obs(), word(1, 7, 0, NONE, 1, NONE));
        else passed++;
        set_issue(5, 0, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, 7, 0, NONE, 1, NONE))
            $display("FAIL commit_stale_kept got %h exp %h", obs(), word(1, 7, 0, NONE, 1, NONE));
        else passed++;
        commit_valid = 1; commit_rd = 5; commit_tag = 7; step();
        set_issue(5, 0, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, NONE))
            $display("FAIL commit_match got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, NONE));
        else passed++;
        // commit bypass: r6->9, then commit(6,9) while reading r6
        set_issue(0, 0, 6, 1, 9); step();
        set_issue(6, 6, 0, 0, 0); commit_valid = 1; commit_rd = 6; commit_tag = 9; step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, NONE))
            $display("FAIL commit_bypass got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, NONE));
        else passed++;
        // same-cycle allocation to commit_rd beats the clear
        set_issue(0, 0, 6, 1, 11); step();
        set_issue(0, 0, 6, 1, 12); commit_valid = 1; commit_rd = 6; commit_tag = 11; step();
        set_issue(6, 0, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, 12, 0, NONE, 1, NONE))
            $display("FAIL commit_alloc_wins got %h exp %h", obs(), word(1, 12, 0, NONE, 1, NONE));
        else passed++;
    endtask

    task automatic test_stall();
        set_issue(0, 0, 7, 1, 13); rob_alloc_valid = 0;
        #1;
        total++;
        if (stall !== 1'b1) $display("FAIL stall_comb got %b exp 1", stall);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL stall_no_valid got %b exp 0", out_valid);
        else passed++;
        idle();
        set_issue(7, 6, 0, 0, 0); rob_alloc_valid = 0;
        #1;
        total++;
        if (stall !== 1'b0) $display("FAIL stall_nodest_comb got %b exp 0", stall);
        else passed++;
        step();
        total++;
        if (obs() !== word(1, NONE, 1, 12, 0, NONE))
            $display("FAIL stall_nodest_accept got %h exp %h", obs(), word(1, NONE, 1, 12, 0, NONE));
        else passed++;
    endtask

    task automatic test_flush();
        set_issue(0, 0, 1, 1, 1); step();
        set_issue(0, 0, 2, 1, 3); step();
        set_issue(0, 0, 3, 1, 4); step();
        set_issue(0, 0, 4, 1, 5); step();
        set_issue(1, 2, 8, 1, 6); cdb_valid = 1; cdb_tag = 3; flush = 1; step();
        total++;
        if (obs() !== word(0, NONE, 1, NONE, 1, 5))
            $display("FAIL flush_drop got %h exp %h", obs(), word(0, NONE, 1, NONE, 1, 5));
        else passed++;
        set_issue(1, 2, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, NONE))
            $display("FAIL flush_r1_r2 got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, NONE));
        else passed++;
        set_issue(3, 4, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, NONE))
            $display("FAIL flush_r3_r4 got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, NONE));
        else passed++;
        set_issue(8, 6, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, NONE))
            $display("FAIL flush_r8_r6 got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, NONE));
        else passed++;
    endtask

    task automatic test_back_to_back();
        set_issue(0, 0, 10, 1, 14); step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, 14))
            $display("FAIL b2b_first got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, 14));
        else passed++;
        // self-reference: reads the old mapping 14, not its own new tag 15
        set_issue(10, 10, 10, 1, 15); step();
        total++;
        if (obs() !== word(1, 14, 0, 14, 0, 15))
            $display("FAIL b2b_self_ref got %h exp %h", obs(), word(1, 14, 0, 14, 0, 15));
        else passed++;
        set_issue(10, 0, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, 15, 0, NONE, 1, NONE))
            $display("FAIL b2b_chain got %h exp %h", obs(), word(1, 15, 0, NONE, 1, NONE));
        else passed++;
        set_issue(0, 0, 0, 1, 16); step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, 16))
            $display("FAIL rd0_dest got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, 16));
        else passed++;
        set_issue(0, 0, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, NONE))
            $display("FAIL rd0_read got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, NONE));
        else passed++;
    endtask

    task automatic test_async_reset();
        set_issue(0, 0, 11, 1, 17); step();
        #3;
        rst_n = 0;
        #1;
        total++;
        if (obs() !== word(0, NONE, 1, NONE, 1, NONE))
            $display("FAIL async_reset_outputs got %h exp %h", obs(), word(0, NONE, 1, NONE, 1, NONE));
        else passed++;
        @(negedge clk);
        rst_n = 1;
        set_issue(11, 10, 0, 0, 0); step();
        total++;
        if (obs() !== word(1, NONE, 1, NONE, 1, NONE))
            $display("FAIL async_reset_rat got %h exp %h", obs(), word(1, NONE, 1, NONE, 1, NONE));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_cdb();
        test_commit();
        test_stall();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
